// File: rtl/tiny32_mem_arbiter_pkg.sv
// Shared types and constants for the tiny32 two-master memory arbiter.
package tiny32_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NWR_W  = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [NWR_W-1:0] NWR_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_e;

  // One master's request as latched for the shared port
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              nrd;
    logic [NWR_W-1:0]  nwr;
  } bus_req_t;

  localparam bus_req_t BUS_IDLE = '{address: '0, data: '0, nrd: 1'b1, nwr: NWR_IDLE};

  function automatic logic is_req(bus_req_t r);
    return !r.nrd || (r.nwr != NWR_IDLE);
  endfunction

endpackage

// File: rtl/tiny32_mem_arbiter_if.sv
// tiny32 CPU-style bus: address/data/strobes one way, read data and ready pulse back.
interface tiny32_mem_arbiter_if;
  import tiny32_mem_arbiter_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              nrd;
  logic [NWR_W-1:0]  nwr;
  logic [DATA_W-1:0] data_in;
  logic              ready;

  modport master (output address, data_out, nrd, nwr, input data_in, ready);
  modport slave  (input address, data_out, nrd, nwr, output data_in, ready);
endinterface

// File: rtl/tiny32_arb_rr.sv
// Two-way request picker: round-robin on ties, or m0 always wins when FIXED_PRIO is set.
module tiny32_arb_rr #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,   // 1 = m1 owned the previous access
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (req0 && req1) begin
      grant_c = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant_c = 2'b01;
    end else if (req1) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/tiny32_mem_arbiter.sv
// Shares one tiny32 memory port between two masters: latch winner, strobe for 1+WAIT_STATES
// cycles (stretched by mem ready), then an idle gap cycle carrying the ready pulse.
module tiny32_mem_arbiter
  import tiny32_mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic                 clk,
  input  logic                 nreset,
  tiny32_mem_arbiter_if.slave  m0,
  tiny32_mem_arbiter_if.slave  m1,
  tiny32_mem_arbiter_if.master mem,
  output logic [1:0]           grant
);

  arb_state_e             state_q, state_d;
  bus_req_t               req0_c, req1_c;
  bus_req_t               lat_q, lat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_q, last_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]             ready_q, ready_d;
  logic [1:0]             pick_c;

  assign req0_c = '{address: m0.address, data: m0.data_out, nrd: m0.nrd, nwr: m0.nwr};
  assign req1_c = '{address: m1.address, data: m1.data_out, nrd: m1.nrd, nwr: m1.nwr};

  tiny32_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .req0       (is_req(req0_c)),
    .req1       (is_req(req1_c)),
    .last_grant (last_q),
    .grant_c    (pick_c)
  );

  // Next-state and next-register values; the latch doubles as the shared strobe register
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    ready_d = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (pick_c != 2'b00) begin
          lat_d   = pick_c[1] ? req1_c : req0_c;
          cnt_d   = CNT_W'(WAIT_STATES);
          grant_d = pick_c;
          last_d  = pick_c[1];
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mem.ready) begin
          if (!lat_q.nrd) begin
            rdata_d[grant_q[1]] = mem.data_in;
          end
          lat_d.nrd = 1'b1;
          lat_d.nwr = NWR_IDLE;
          ready_d   = grant_q;
          grant_d   = 2'b00;
          state_d   = ARB_GAP;
        end
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ARB_IDLE;
      lat_q   <= BUS_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      rdata_q <= '0;
      ready_q <= 2'b00;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign mem.address  = lat_q.address;
  assign mem.data_out = lat_q.data;
  assign mem.nrd      = lat_q.nrd;
  assign mem.nwr      = lat_q.nwr;
  assign m0.data_in   = rdata_q[0];
  assign m1.data_in   = rdata_q[1];
  assign m0.ready     = ready_q[0];
  assign m1.ready     = ready_q[1];
  assign grant        = grant_q;

endmodule

// File: tb/tb_tiny32_mem_arbiter.sv
// Bench: two arbiter configurations driven by contract-following random masters,
// checked every cycle against a transaction-level timing model.
module tb_tiny32_mem_arbiter;
  import tiny32_mem_arbiter_pkg::*;

  localparam int N_EDGES = 1500;
  localparam int N_SC    = 6;

  typedef struct packed {
    logic        nrd;
    logic [3:0]  nwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  grant;
    logic [1:0]  ready;
    logic [31:0] din0;
    logic [31:0] din1;
  } obs_t;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  bus_req_t    drv    [2][2];
  logic        mrdy   [2];
  logic [31:0] mrdata [2];
  obs_t        obs    [2];

  // dut 0: WAIT_STATES=1 round-robin; dut 1: WAIT_STATES=0 fixed priority
  for (genvar d = 0; d < 2; d++) begin : g_dut
    tiny32_mem_arbiter_if m0_if ();
    tiny32_mem_arbiter_if m1_if ();
    tiny32_mem_arbiter_if mem_if ();
    logic [1:0] grant_w;

    tiny32_mem_arbiter #(.WAIT_STATES(d == 0 ? 1 : 0), .FIXED_PRIO(d == 1)) u_dut (
      .clk    (clk),
      .nreset (nreset),
      .m0     (m0_if),
      .m1     (m1_if),
      .mem    (mem_if),
      .grant  (grant_w)
    );

    assign m0_if.address  = drv[d][0].address;
    assign m0_if.data_out = drv[d][0].data;
    assign m0_if.nrd      = drv[d][0].nrd;
    assign m0_if.nwr      = drv[d][0].nwr;
    assign m1_if.address  = drv[d][1].address;
    assign m1_if.data_out = drv[d][1].data;
    assign m1_if.nrd      = drv[d][1].nrd;
    assign m1_if.nwr      = drv[d][1].nwr;
    assign mem_if.ready   = mrdy[d];
    assign mem_if.data_in = mrdata[d];

    assign obs[d] = '{nrd: mem_if.nrd, nwr: mem_if.nwr, addr: mem_if.address,
                      wdata: mem_if.data_out, grant: grant_w,
                      ready: {m1_if.ready, m0_if.ready},
                      din0: m0_if.data_in, din1: m1_if.data_in};
  end

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int m0_quiet_until = -1;

  // Reference model: one record per DUT describing the access in flight
  bit          busy      [2];
  int          owner     [2];
  int          acc_start [2];
  int          done_edge [2];
  int          last      [2];
  bus_req_t    lat       [2];
  logic [31:0] exp_din   [2][2];

  bit          outst     [2][2];
  bit          dropped   [2][2];
  int          sc_idx    [2][2];
  int          sc_at     [2][N_SC];
  bus_req_t    sc_req    [2][N_SC];

  function automatic int ws_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bus_req_t mk(logic [31:0] a, logic [31:0] dat, logic rd, logic [3:0] wr);
    bus_req_t r;
    r.address = a; r.data = dat; r.nrd = rd; r.nwr = wr;
    return r;
  endfunction

  function automatic bus_req_t rand_req();
    int k;
    k = int'($urandom_range(3));
    return mk($urandom, $urandom, k == 2 ? 1'b1 : 1'b0,
              (k < 2) ? 4'hF : 4'($urandom_range(14)));
  endfunction

  task automatic check_eq(input string tag, input int d, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d edge %0d: got %h expected %h", tag, d, edge_n, got, exp);
    end
  endtask

  task automatic reset_model(input int d);
    busy[d] = 1'b0; owner[d] = 0; acc_start[d] = 0; done_edge[d] = -10;
    last[d] = 1; lat[d] = BUS_IDLE;
    exp_din[d][0] = '0; exp_din[d][1] = '0;
  endtask

  task automatic check_outputs(input int d);
    logic [1:0] oh;
    oh = (owner[d] == 1) ? 2'b10 : 2'b01;
    check_eq("strobes", d, 64'({obs[d].nrd, obs[d].nwr}),
             64'(busy[d] ? {lat[d].nrd, lat[d].nwr} : 5'h1F));
    check_eq("address", d, 64'(obs[d].addr), 64'(lat[d].address));
    check_eq("wdata",   d, 64'(obs[d].wdata), 64'(lat[d].data));
    check_eq("grant",   d, 64'(obs[d].grant), 64'(busy[d] ? oh : 2'b00));
    check_eq("ready",   d, 64'(obs[d].ready), 64'((done_edge[d] == edge_n) ? oh : 2'b00));
    check_eq("din0",    d, 64'(obs[d].din0), 64'(exp_din[d][0]));
    check_eq("din1",    d, 64'(obs[d].din1), 64'(exp_din[d][1]));
  endtask

  // Advance the model across one rising edge using exactly what was driven
  task automatic model_edge(input int d);
    bit r0, r1;
    int w;
    if (busy[d]) begin
      if (edge_n >= acc_start[d] + ws_of(d) + 1 && mrdy[d]) begin
        busy[d] = 1'b0;
        done_edge[d] = edge_n;
        if (!lat[d].nrd) exp_din[d][owner[d]] = mrdata[d];
        lat[d].nrd = 1'b1;
        lat[d].nwr = 4'hF;
      end
    end else if (edge_n >= done_edge[d] + 2) begin
      r0 = is_req(drv[d][0]);
      r1 = is_req(drv[d][1]);
      if (r0 || r1) begin
        if (r0 && r1) w = (d == 1) ? 0 : 1 - last[d];
        else          w = r0 ? 0 : 1;
        owner[d] = w; last[d] = w; lat[d] = drv[d][w];
        busy[d] = 1'b1; acc_start[d] = edge_n;
      end
    end
  endtask

  // Master behaviour: hold request until its ready pulse, may drop strobes once granted
  task automatic master_update(input int d, input int m, input int e);
    if (outst[d][m] && done_edge[d] == edge_n && owner[d] == m) begin
      outst[d][m] = 1'b0; dropped[d][m] = 1'b0; drv[d][m] = BUS_IDLE;
    end
    if (outst[d][m] && busy[d] && owner[d] == m && !dropped[d][m] && $urandom_range(5) == 0) begin
      drv[d][m] = BUS_IDLE; dropped[d][m] = 1'b1;
    end
    if (!outst[d][m] && !(m == 0 && e <= m0_quiet_until)) begin
      if (sc_idx[d][m] < N_SC && sc_at[m][sc_idx[d][m]] <= e) begin
        drv[d][m] = sc_req[m][sc_idx[d][m]];
        sc_idx[d][m]++;
        outst[d][m] = 1'b1;
      end else if (sc_idx[d][m] == N_SC && e > 40 && $urandom_range(2) == 0) begin
        drv[d][m] = rand_req();
        outst[d][m] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      reset_model(d);
      check_outputs(d);
      for (int m = 0; m < 2; m++) begin
        outst[d][m] = 1'b0; dropped[d][m] = 1'b0; drv[d][m] = BUS_IDLE;
      end
      drv[d][1] = mk(32'h4000_0300, 32'h0, 1'b0, 4'hF);
      outst[d][1] = 1'b1;
    end
    m0_quiet_until = edge_n + 1;
    #1 nreset = 1'b1;
  endtask

  initial begin
    bit did_reset;
    int e;
    sc_at[0] = '{1, 12, 20, 36, 0, 0};
    sc_at[1] = '{4, 12, 20, 28, 60, 60};
    sc_req[0][0] = mk(32'h4000_0010, 32'h0, 1'b0, 4'hF);
    sc_req[0][1] = mk(32'h4000_0100, 32'h0, 1'b0, 4'hF);
    sc_req[0][2] = mk(32'h4000_0104, 32'hAAAA_5555, 1'b1, 4'h0);
    sc_req[0][3] = mk(32'h4000_0108, 32'h0, 1'b0, 4'hF);
    sc_req[0][4] = mk(32'h4000_010C, 32'h0, 1'b0, 4'hF);
    sc_req[0][5] = mk(32'h4000_0110, 32'h0, 1'b0, 4'hF);
    sc_req[1][0] = mk(32'h4000_0020, 32'h1234_5678, 1'b1, 4'b1100);
    sc_req[1][1] = mk(32'h4000_0200, 32'h0, 1'b0, 4'hF);
    sc_req[1][2] = mk(32'h4000_0204, 32'h0, 1'b0, 4'hF);
    sc_req[1][3] = mk(32'h4000_0030, 32'h0, 1'b0, 4'hF);
    sc_req[1][4] = mk(32'h4000_0034, 32'hCAFE_F00D, 1'b1, 4'b0110);
    sc_req[1][5] = mk(32'h4000_0038, 32'h5A5A_A5A5, 1'b0, 4'b0011);
    for (int d = 0; d < 2; d++) begin
      reset_model(d);
      mrdy[d] = 1'b1; mrdata[d] = '0;
      for (int m = 0; m < 2; m++) begin
        drv[d][m] = BUS_IDLE; outst[d][m] = 1'b0; dropped[d][m] = 1'b0; sc_idx[d][m] = 0;
      end
    end
    #1 nreset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d);
    nreset = 1'b1;
    did_reset = 1'b0;

    for (int i = 0; i < N_EDGES; i++) begin
      e = edge_n + 1;
      for (int d = 0; d < 2; d++) begin
        if (e >= 29 && e <= 33)  mrdy[d] = 1'b0;
        else if (e < 40)         mrdy[d] = 1'b1;
        else                     mrdy[d] = ($urandom_range(3) != 0);
        mrdata[d] = (e < 8) ? 32'hDEAD_BEEF : $urandom;
        for (int m = 0; m < 2; m++) master_update(d, m, e);
      end
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < 2; d++) model_edge(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_outputs(d);
      if (!did_reset && edge_n >= 600 && busy[0]) begin
        do_reset();
        did_reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
